// File: rtl/request_encoder.sv
// 4-to-2 handshaked request encoder: latches request pulses and presents one
// requester's index with an enable qualifier until the consumer acknowledges it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no code presented (enable=0); grant on next edge if any pending
// HOLD  | code presented (enable=1); address frozen until ack
module request_encoder #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ack,
    output logic address0,
    output logic address1,
    output logic enable
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] clr;
    logic [1:0] sel;

    // Scan from ptr upward; descending loop so the smallest offset wins.
    always_comb begin
        sel = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (pending_q[ptr_q + 2'(k)]) begin
                sel = ptr_q + 2'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        clr     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    addr_d  = sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    clr[addr_q] = 1'b1;
                    state_d     = IDLE;
                    if (ROUND_ROBIN) begin
                        ptr_d = addr_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A new pulse on the accept edge re-arms the line.
        pending_d = (pending_q & ~clr) | {in3, in2, in1, in0};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            ptr_q     <= 2'b00;
            addr_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
        end
    end

    assign enable   = (state_q == HOLD);
    assign address0 = addr_q[0];
    assign address1 = addr_q[1];

endmodule
